au_gray2bin_pipe: RTL

- Pipelined Gray-to-binary decoder with valid/ready handshakes on both sides. It is the inverse of the existing binary-to-Gray encoder.
- Sits at the receive end of Gray-coded paths (CDC pointers, position counters) and returns the binary word.
- Decode is a prefix XOR from MSB to LSB, split across STAGES register stages to meet timing at large WIDTH.

---
 rtl/au_gray2bin_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/au_gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder: prefix XOR from MSB down, split over STAGES
// register stages with valid/ready on both sides. Define AU_GRAY2BIN_STEP_CHECK_EN for step_err.
module au_gray2bin_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] g,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] b
`ifdef AU_GRAY2BIN_STEP_CHECK_EN
   ,
   output logic             step_err
`endif
);

   localparam int C = (WIDTH + STAGES - 1) / STAGES;

   // Bits above hi are already binary; bits below lo are still Gray and pass through.
   function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] w, input int lo, input int hi);
      logic [WIDTH-1:0] r;
      r = w;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (i >= lo && i <= hi) r[i] = r[i+1] ^ w[i];
      end
      return r;
   endfunction

   logic [STAGES-1:0] valid_q;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  res_d  [STAGES];
   logic [STAGES-1:0] src_vld;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;

`ifdef AU_GRAY2BIN_STEP_CHECK_EN
   logic [STAGES-1:0] err_q;
   logic [STAGES-1:0] src_err;
   logic [WIDTH-1:0]  g_prev_q;
   logic              prev_vld_q;
   logic              err_in_d;
   logic              in_xfer;
`endif

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int HI     = WIDTH - 1 - gi * C;
         localparam int LO_RAW = WIDTH - (gi + 1) * C;
         localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;
         if (gi == 0) begin : g_first
            assign res_d[gi]   = resolve(g, LO, HI);
            assign src_vld[gi] = in_valid;
`ifdef AU_GRAY2BIN_STEP_CHECK_EN
            assign src_err[gi] = err_in_d;
`endif
         end else begin : g_rest
            assign res_d[gi]   = resolve(data_q[gi-1], LO, HI);
            assign src_vld[gi] = valid_q[gi-1];
`ifdef AU_GRAY2BIN_STEP_CHECK_EN
            assign src_err[gi] = err_q[gi-1];
`endif
         end
      end
   endgenerate

   // A stage advances when it is full and some later stage has room (or the output drains).
   always_comb begin
      logic full_above;
      adv        = '0;
      load       = '0;
      full_above = 1'b1;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k]     = valid_q[k] && (out_ready || !full_above);
         load[k]    = !valid_q[k] || adv[k];
         full_above = full_above && valid_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               valid_q[k] <= src_vld[k];
               if (src_vld[k]) data_q[k] <= res_d[k];
            end
         end
      end
   end

   assign in_ready  = load[0];
   assign out_valid = valid_q[STAGES-1];
   assign b         = data_q[STAGES-1];

`ifdef AU_GRAY2BIN_STEP_CHECK_EN
   assign in_xfer  = in_valid && in_ready;
   assign err_in_d = prev_vld_q && ($countones(g ^ g_prev_q) != 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q      <= '0;
         g_prev_q   <= '0;
         prev_vld_q <= 1'b0;
      end else begin
         if (in_xfer) begin
            g_prev_q   <= g;
            prev_vld_q <= 1'b1;
         end
         for (int k = 0; k < STAGES; k++) begin
            if (load[k] && src_vld[k]) err_q[k] <= src_err[k];
         end
      end
   end

   assign step_err = err_q[STAGES-1];
`endif

endmodule
